// File: rtl/bram_arb_pkg.sv
// Shared defaults, FSM encoding and read-tag type for the two-port BRAM
// round-robin arbiter.
package bram_arb_pkg;

  localparam int unsigned AW_DEF        = 10;
  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned RD_LAT_DEF    = 1;
  localparam int unsigned MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic arb_state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register carrying {valid, requester id} alongside each BRAM read so
// the returning data can be steered to the requester that issued it.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic       push_id,
  output logic [1:0] rvalid
);

  rd_tag_t [RD_LAT:0] stage_q;
  rd_tag_t [RD_LAT:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = '{valid: push_valid, id: push_id};
    for (int k = 1; k <= int'(RD_LAT); k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // NOTE: this pipeline is reset, unlike a data RAM, because a stale valid
  // bit left over from before reset would fire a spurious rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign rvalid = {stage_q[RD_LAT].valid &  stage_q[RD_LAT].id,
                   stage_q[RD_LAT].valid & ~stage_q[RD_LAT].id};

endmodule

// File: rtl/bram_rr_arb.sv
// Two-requester round-robin arbiter in front of one single-port BRAM, with
// lockable bursts capped at MAX_BURST and per-requester read return.
module bram_rr_arb
  import bram_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned RD_LAT    = RD_LAT_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic [0:0]      clk,
  input  logic [0:0]      rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [1:0]      lock,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            bram_en,
  output logic            bram_we,
  output logic [AW-1:0]   bram_addr,
  output logic [DW-1:0]   bram_din,
  input  logic [DW-1:0]   bram_dout
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel;
  logic          push_valid;

  logic          bram_en_q, bram_en_d;
  logic          bram_we_q, bram_we_d;
  logic [AW-1:0] bram_addr_q, bram_addr_d;
  logic [DW-1:0] bram_din_q, bram_din_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    gnt     = 2'b00;
    sel     = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE:    gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
      OWN0:    gnt = (req[0] && lock[0]) ? 2'b01 : 2'b00;
      OWN1:    gnt = (req[1] && lock[1]) ? 2'b10 : 2'b00;
      default: gnt = 2'b00;
    endcase
    if (!rst) gnt = 2'b00;
    sel = gnt[1];

    if (gnt != 2'b00) begin
      last_d = sel;
      if (state_q == IDLE) begin
        if (lock[sel] && (MAX_BURST > 1)) begin
          state_d = own_state(sel);
          cnt_d   = CW'(1);
        end
      end else if (cnt_q == CW'(MAX_BURST - 1)) begin
        // Cap reached: last_d already names the owner, so the other side wins
        // the tie in the following IDLE cycle.
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bram_en_d   = |gnt;
    bram_we_d   = |gnt & we[sel];
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    if (|gnt) begin
      bram_addr_d = sel ? addr[AW +: AW]  : addr[0 +: AW];
      bram_din_d  = sel ? wdata[DW +: DW] : wdata[0 +: DW];
    end
  end

  assign push_valid = |gnt & ~we[sel];

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_id    (sel),
    .rvalid     (rvalid)
  );

  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign rdata     = bram_dout;

endmodule

// File: tb/tb_bram_rr_arb.sv
// Bench for bram_rr_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration rules and the BRAM.
module tb_bram_rr_arb;

  localparam int AW        = 10;
  localparam int DW        = 16;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req, we, lock, gnt, rvalid;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]   rdata, bram_din, bram_dout;
  logic            bram_en, bram_we;
  logic [AW-1:0]   bram_addr;

  logic [1:0]      req3, gnt3, rvalid3;
  logic [2*AW-1:0] addr3;
  logic [DW-1:0]   rdata3, bram_din3, bram_dout3;
  logic            bram_en3, bram_we3;
  logic [AW-1:0]   bram_addr3;

  bram_rr_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout));

  bram_rr_arb #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_BURST(MAX_BURST)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(2'b00), .lock(2'b00), .addr(addr3), .wdata('0),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .bram_en(bram_en3), .bram_we(bram_we3),
    .bram_addr(bram_addr3), .bram_din(bram_din3), .bram_dout(bram_dout3));

  // Power-up contents of every BRAM location not yet written.
  function automatic logic [DW-1:0] pat(input int a);
    return DW'((a * 257) ^ 'hC35A);
  endfunction

  // Behavioural BRAMs: registered read, RD_LAT cycles from bram_en to data.
  logic [DW-1:0]       mem [1<<AW];
  bit [(1<<AW)-1:0]    wr_mask;
  logic [DW-1:0]       rpipe [RD_LAT];
  always @(posedge clk) begin
    if (bram_en && bram_we) begin
      mem[bram_addr]     <= bram_din;
      wr_mask[bram_addr] <= 1'b1;
    end
    if (bram_en && !bram_we)
      rpipe[0] <= wr_mask[bram_addr] ? mem[bram_addr] : pat(int'(bram_addr));
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bram_dout = rpipe[RD_LAT-1];

  logic [DW-1:0] rpipe3 [3];
  always @(posedge clk) begin
    if (bram_en3 && !bram_we3) rpipe3[0] <= pat(int'(bram_addr3));
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign bram_dout3 = rpipe3[2];

  // Reference model state.
  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  int            m_owner = -1;
  int            m_cnt   = 0;
  bit            m_last  = 1'b1;
  int            cyc     = 0;
  logic [DW-1:0] ref_mem [int];
  op_t           x_op [int];
  logic [1:0]    x_rv [int];
  logic [DW-1:0] x_rd [int];

  int n_checks = 0;
  int n_bad    = 0;

  logic [1:0]    o_gnt, e_gnt, o_rv, e_rv;
  logic          o_en, e_en, o_we, e_we;
  logic [AW-1:0] o_addr, e_addr;
  logic [DW-1:0] o_din, e_din, o_rd, e_rd;

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [1:0] model_gnt(input logic [1:0] r, input logic [1:0] l);
    if (m_owner >= 0) return (r[m_owner] && l[m_owner]) ? 2'(1 << m_owner) : 2'b00;
    if (r == 2'b11)   return m_last ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1'b1;
    x_op.delete();
    x_rv.delete();
    x_rd.delete();
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  // One clock: sample gnt mid-cycle, advance the model, then sample the
  // registered outputs just after the edge. Called and returns at negedge.
  task automatic tick();
    logic [1:0] g;
    int         s;
    int         a;
    #1;
    o_gnt = gnt;
    g     = model_gnt(req, lock);
    e_gnt = g;
    if (g != 2'b00) begin
      s = g[1] ? 1 : 0;
      a = int'(addr[s*AW +: AW]);
      x_op[cyc + 1] = '{en: 1'b1, we: we[s], addr: addr[s*AW +: AW], din: wdata[s*DW +: DW]};
      if (we[s]) begin
        ref_mem[a] = wdata[s*DW +: DW];
      end else begin
        x_rv[cyc + 1 + RD_LAT] = g;
        x_rd[cyc + 1 + RD_LAT] = ref_read(a);
      end
      m_last = s[0];
      if (m_owner < 0) begin
        if (lock[s] && MAX_BURST > 1) begin
          m_owner = s;
          m_cnt   = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == MAX_BURST) begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end else if (m_owner >= 0) begin
      m_owner = -1;
      m_cnt   = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    o_en = bram_en; o_we = bram_we; o_addr = bram_addr; o_din = bram_din;
    o_rv = rvalid;  o_rd = rdata;
    if (x_op.exists(cyc)) begin
      e_en = x_op[cyc].en; e_we = x_op[cyc].we; e_addr = x_op[cyc].addr; e_din = x_op[cyc].din;
    end else begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
    end
    e_rv = x_rv.exists(cyc) ? x_rv[cyc] : 2'b00;
    e_rd = x_rd.exists(cyc) ? x_rd[cyc] : '0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b00, 2'b11, AW'(1), AW'(2), '0, '0);
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got=%b want=00", gnt); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 || rvalid !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%0d din=%h rvalid=%b want all zero",
               bram_en, bram_we, bram_addr, bram_din, rvalid);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  task automatic test_tie();
    drive(2'b11, 2'b00, 2'b00, AW'(5), AW'(9), '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01) begin n_bad++; $display("FAIL tie_first_gnt: got=%b want=01", o_gnt); end
    n_checks++;
    if (o_en !== 1'b1 || o_we !== 1'b0 || o_addr !== AW'(5)) begin
      n_bad++; $display("FAIL tie_bram_c1: en=%b we=%b addr=%0d want en=1 we=0 addr=5", o_en, o_we, o_addr);
    end
    tick();
    n_checks++;
    if (o_gnt !== 2'b10) begin n_bad++; $display("FAIL tie_second_gnt: got=%b want=10", o_gnt); end
    n_checks++;
    if (o_rv !== 2'b01 || o_rd !== pat(5)) begin
      n_bad++; $display("FAIL tie_rvalid0_c2: rvalid=%b rdata=%h want 01/%h", o_rv, o_rd, pat(5));
    end
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    n_checks++;
    if (o_rv !== 2'b10 || o_rd !== pat(9)) begin
      n_bad++; $display("FAIL tie_rvalid1_c3: rvalid=%b rdata=%h want 10/%h", o_rv, o_rd, pat(9));
    end
    tick();
    n_checks++;
    if (o_rv !== 2'b00) begin n_bad++; $display("FAIL tie_rvalid_single: rvalid=%b want=00", o_rv); end
  endtask

  task automatic test_write_read();
    drive(2'b01, 2'b01, 2'b00, AW'(3), '0, 16'h1234, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01) begin n_bad++; $display("FAIL wr_gnt: got=%b want=01", o_gnt); end
    n_checks++;
    if (o_en !== 1'b1 || o_we !== 1'b1 || o_addr !== AW'(3) || o_din !== 16'h1234) begin
      n_bad++;
      $display("FAIL wr_bram_c1: en=%b we=%b addr=%0d din=%h want 1/1/3/1234", o_en, o_we, o_addr, o_din);
    end
    drive(2'b01, 2'b00, 2'b00, AW'(3), '0, '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01 || o_we !== 1'b0 || o_rv !== 2'b00) begin
      n_bad++; $display("FAIL rd_issue: gnt=%b we=%b rvalid=%b want 01/0/00", o_gnt, o_we, o_rv);
    end
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    n_checks++;
    if (o_rv !== 2'b01 || o_rd !== 16'h1234) begin
      n_bad++; $display("FAIL rd_after_wr: rvalid=%b rdata=%h want 01/1234", o_rv, o_rd);
    end
    tick();
  endtask

  task automatic test_burst_cap();
    int         n0 = 0;
    int         n1 = 0;
    int         first_bad = -1;
    logic [1:0] seq [$];
    logic [1:0] want;
    for (int t = 0; t < 80 && !(n0 >= 20 && n1 >= 1); t++) begin
      drive({1'(t >= 1 && n1 < 1), 1'(n0 < 20)}, 2'b00, 2'b01,
            AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)), '0, '0);
      tick();
      if (o_gnt != 2'b00) seq.push_back(o_gnt);
      if (o_gnt[0]) n0++;
      if (o_gnt[1]) n1++;
      n_checks++;
      if (o_gnt !== e_gnt || o_rv !== e_rv || (e_rv != 2'b00 && o_rd !== e_rd)) begin
        n_bad++;
        $display("FAIL burst_cycle: gnt=%b rvalid=%b rdata=%h want %b/%b/%h", o_gnt, o_rv, o_rd, e_gnt, e_rv, e_rd);
      end
    end
    for (int i = 0; i < 21; i++) begin
      want = (i == 16) ? 2'b10 : 2'b01;
      if (first_bad < 0 && (i >= seq.size() || seq[i] !== want)) first_bad = i;
    end
    n_checks++;
    if (seq.size() != 21 || first_bad >= 0) begin
      n_bad++;
      $display("FAIL burst_sequence: grants=%0d first_wrong_index=%0d want 16x01,10,4x01", seq.size(), first_bad);
    end
    idle(4);
  endtask

  task automatic test_lock_drop();
    drive(2'b01, 2'b00, 2'b01, AW'(20), AW'(30), '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01) begin n_bad++; $display("FAIL lockdrop_enter: got=%b want=01", o_gnt); end
    for (int i = 1; i < 4; i++) begin
      drive(2'b11, 2'b00, 2'b01, AW'(20 + i), AW'(30), '0, '0);
      tick();
      n_checks++;
      if (o_gnt !== 2'b01) begin n_bad++; $display("FAIL lockdrop_held_%0d: got=%b want=01", i, o_gnt); end
    end
    drive(2'b11, 2'b00, 2'b00, AW'(24), AW'(30), '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b00) begin n_bad++; $display("FAIL lockdrop_release: got=%b want=00", o_gnt); end
    tick();
    n_checks++;
    if (o_gnt !== 2'b10) begin n_bad++; $display("FAIL lockdrop_other: got=%b want=10", o_gnt); end
    idle(4);
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      drive({1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)}, 2'($urandom),
            ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom),
            AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
      tick();
      n_checks++;
      if (o_gnt !== e_gnt) begin n_bad++; $display("FAIL rand_gnt t=%0d: got=%b want=%b", t, o_gnt, e_gnt); end
      n_checks++;
      if (o_en !== e_en || o_we !== e_we || (e_en && o_addr !== e_addr) || (e_we && o_din !== e_din)) begin
        n_bad++;
        $display("FAIL rand_bram t=%0d: en=%b we=%b addr=%0d din=%h want %b/%b/%0d/%h",
                 t, o_en, o_we, o_addr, o_din, e_en, e_we, e_addr, e_din);
      end
      n_checks++;
      if (o_rv !== e_rv || (e_rv != 2'b00 && o_rd !== e_rd)) begin
        n_bad++; $display("FAIL rand_read t=%0d: rvalid=%b rdata=%h want %b/%h", t, o_rv, o_rd, e_rv, e_rd);
      end
    end
    idle(4);
  endtask

  task automatic test_reset_mid_read();
    drive(2'b01, 2'b00, 2'b00, AW'(7), '0, '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01 || o_en !== 1'b1) begin
      n_bad++; $display("FAIL midrst_accept: gnt=%b en=%b want 01/1", o_gnt, o_en);
    end
    drive(2'b11, 2'b00, 2'b00, AW'(7), AW'(8), '0, '0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 2'b00 || bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0) begin
      n_bad++;
      $display("FAIL midrst_async: gnt=%b en=%b we=%b addr=%0d din=%h want all zero",
               gnt, bram_en, bram_we, bram_addr, bram_din);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rvalid !== 2'b00 || bram_en !== 1'b0) begin
        n_bad++; $display("FAIL midrst_hold_%0d: rvalid=%b en=%b want 00/0", i, rvalid, bram_en);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(2'b11, 2'b00, 2'b00, AW'(2), AW'(4), '0, '0);
    tick();
    n_checks++;
    if (o_gnt !== 2'b01) begin n_bad++; $display("FAIL midrst_tie: got=%b want=01", o_gnt); end
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (o_rv !== e_rv || (e_rv != 2'b00 && o_rd !== e_rd)) begin
        n_bad++; $display("FAIL midrst_after_%0d: rvalid=%b rdata=%h want %b/%h", i, o_rv, o_rd, e_rv, e_rd);
      end
    end
  endtask

  task automatic test_lat3();
    req3  = 2'b01;
    addr3 = {AW'(0), AW'(11)};
    #1;
    n_checks++;
    if (gnt3 !== 2'b01) begin n_bad++; $display("FAIL lat3_gnt: got=%b want=01", gnt3); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      req3 = 2'b00;
      if (k == 1) begin
        n_checks++;
        if (bram_en3 !== 1'b1 || bram_addr3 !== AW'(11)) begin
          n_bad++; $display("FAIL lat3_bram_c1: en=%b addr=%0d want 1/11", bram_en3, bram_addr3);
        end
      end
      n_checks++;
      if (rvalid3 !== ((k == 4) ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL lat3_rvalid_c%0d: got=%b want=%b", k, rvalid3, (k == 4) ? 2'b01 : 2'b00);
      end
      if (k == 4) begin
        n_checks++;
        if (rdata3 !== pat(11)) begin n_bad++; $display("FAIL lat3_rdata: got=%h want=%h", rdata3, pat(11)); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req3  = 2'b00;
    addr3 = '0;
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    test_reset();
    test_tie();
    test_write_read();
    test_burst_cap();
    test_lock_drop();
    test_random();
    test_reset_mid_read();
    test_lat3();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_rr_arb.md
BRAM_RR_ARB -- requirements
Module: bram_rr_arb

Interface
REQ-001 SHALL have parameter AW, default 10, meaning BRAM address width.
REQ-002 SHALL have parameter DW, default 16, meaning BRAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1 (legal 1..3), meaning BRAM read latency in cycles.
REQ-004 SHALL have parameter MAX_BURST, default 16, meaning the maximum number of consecutive locked accesses.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, 2 bits: per-requester access request.
REQ-008 SHALL have port we, input, 2 bits: per-requester write enable (1 = write, 0 = read).
REQ-009 SHALL have port lock, input, 2 bits: per-requester burst-hold request.
REQ-010 SHALL have port addr, input, 2*AW bits: requester i address at [i*AW +: AW].
REQ-011 SHALL have port wdata, input, 2*DW bits: requester i write data at [i*DW +: DW].
REQ-012 SHALL have port gnt, output, 2 bits: one-hot or zero; high marks the cycle in which the access is accepted.
REQ-013 SHALL have port rvalid, output, 2 bits: read data valid for requester i.
REQ-014 SHALL have port rdata, output, DW bits: shared read data, qualified by rvalid.
REQ-015 SHALL have port bram_en, output, 1 bit: BRAM port enable.
REQ-016 SHALL have port bram_we, output, 1 bit: BRAM write enable.
REQ-017 SHALL have port bram_addr, output, AW bits: BRAM address.
REQ-018 SHALL have port bram_din, output, DW bits: BRAM write data.
REQ-019 SHALL have port bram_dout, input, DW bits: BRAM read data.

Function
REQ-020 SHALL accept at most one access per cycle; gnt[i] is combinational from req and state, and the requester's we/addr/wdata are sampled on the edge ending the gnt cycle.
REQ-021 SHALL drive bram_en/bram_we/bram_addr/bram_din from registers in the cycle after acceptance (cycle 1), and drive bram_en = 0 and bram_we = 0 when nothing was accepted.
REQ-022 SHALL assert rvalid[i] for exactly one cycle, in cycle 1+RD_LAT after acceptance of a read, with rdata = bram_dout; writes produce no rvalid.
REQ-023 SHALL implement FSM states IDLE, OWN0 and OWN1.
REQ-024 SHALL, in IDLE, grant the single requester when only one has req high; when both do, grant the one not held in the last-grant pointer; the pointer then updates to the granted index.
REQ-025 SHALL move IDLE -> OWNi when requester i is granted with lock[i] = 1.
REQ-026 SHALL, in OWNi, grant only requester i while req[i] && lock[i], and count accepted accesses including the entering one.
REQ-027 SHALL move OWNi -> IDLE when lock[i] falls, when req[i] falls (no grant in that cycle), or after MAX_BURST accesses.
REQ-028 SHALL, after a forced release at MAX_BURST, give the other requester priority in the next IDLE cycle if it is requesting.
REQ-029 SHALL preserve issue order on the BRAM and provide no forwarding; a read following a same-address write returns data per the BRAM write mode.
REQ-030 SHALL ignore lock[i] while req[i] = 0.

Reset
REQ-031 SHALL, on rst low, asynchronously force: state = IDLE, last-grant pointer = 1 (requester 0 wins the first tie), burst count = 0, bram_en = bram_we = 0, bram_addr = 0, bram_din = 0, rvalid = 0, and the read tag pipeline cleared; gnt = 0 while rst is low.
REQ-032 SHALL drop reads in flight at reset, producing no rvalid for them after release.

Structure
REQ-033 SHALL place the FSM state encodings and parameter defaults (AW, DW, RD_LAT, MAX_BURST) in shared package bram_arb_pkg.
REQ-034 SHALL use one sub-module, rd_tag_pipe: a RD_LAT+1 stage shift register carrying {valid, requester id} that generates rvalid.

Verification
REQ-035 Tie: both requesters read (addr0 = 5, addr1 = 9) after reset -> gnt = 01, then gnt = 10; rvalid[0] in cycle 2 and rvalid[1] in cycle 3 (RD_LAT = 1).
REQ-036 Write/read: req0 writes 16'h1234 to address 3, then reads address 3 -> bram_we high in cycle 1; rvalid[0] with rdata = 16'h1234.
REQ-037 Burst cap: req0 holds lock with 20 reads while req1 is pending -> 16 consecutive gnt[0], then gnt[1], then requester 0 resumes.
REQ-038 Lock drop: lock0 falls after 4 accesses while req1 is pending -> gnt[1] in the next cycle.
REQ-039 Reset mid-read: assert rst low one cycle after a read is accepted -> rvalid stays 0 and the BRAM outputs are 0; after release, a tie grants requester 0.
REQ-040 RD_LAT = 3: a single read -> rvalid in cycle 4, and no rvalid in cycles 1-3.
